// File: rtl/bram_stream_arbiter_if.sv
// Stream bundle between two requesters, the arbiter and the single-port buffer.
// The slave modport is the arbiter's view; master is the surrounding system.
interface bram_stream_arbiter_if #(
  parameter int INST_W = 64,
  parameter int DATA_W = 128
);
  localparam int KEEP_W = DATA_W / 8;

  logic [INST_W-1:0] s_instruct_0_tdata, s_instruct_1_tdata;
  logic              s_instruct_0_tvalid, s_instruct_1_tvalid;
  logic              s_instruct_0_tready, s_instruct_1_tready;

  logic [DATA_W-1:0] s_in_0_tdata, s_in_1_tdata;
  logic [KEEP_W-1:0] s_in_0_tkeep, s_in_1_tkeep;
  logic              s_in_0_tlast, s_in_1_tlast;
  logic              s_in_0_tvalid, s_in_1_tvalid;
  logic              s_in_0_tready, s_in_1_tready;

  logic [DATA_W-1:0] m_out_0_tdata, m_out_1_tdata;
  logic [KEEP_W-1:0] m_out_0_tkeep, m_out_1_tkeep;
  logic              m_out_0_tlast, m_out_1_tlast;
  logic              m_out_0_tvalid, m_out_1_tvalid;
  logic              m_out_0_tready, m_out_1_tready;

  logic [INST_W-1:0] m_instruct_tdata;
  logic              m_instruct_tvalid, m_instruct_tready;

  logic [DATA_W-1:0] m_in_tdata;
  logic [KEEP_W-1:0] m_in_tkeep;
  logic              m_in_tlast, m_in_tvalid, m_in_tready;

  logic [DATA_W-1:0] s_out_tdata;
  logic [KEEP_W-1:0] s_out_tkeep;
  logic              s_out_tlast, s_out_tvalid, s_out_tready;

  modport slave (
    input  s_instruct_0_tdata, s_instruct_1_tdata, s_instruct_0_tvalid, s_instruct_1_tvalid,
    output s_instruct_0_tready, s_instruct_1_tready,
    input  s_in_0_tdata, s_in_1_tdata, s_in_0_tkeep, s_in_1_tkeep,
    input  s_in_0_tlast, s_in_1_tlast, s_in_0_tvalid, s_in_1_tvalid,
    output s_in_0_tready, s_in_1_tready,
    output m_out_0_tdata, m_out_1_tdata, m_out_0_tkeep, m_out_1_tkeep,
    output m_out_0_tlast, m_out_1_tlast, m_out_0_tvalid, m_out_1_tvalid,
    input  m_out_0_tready, m_out_1_tready,
    output m_instruct_tdata, m_instruct_tvalid,
    input  m_instruct_tready,
    output m_in_tdata, m_in_tkeep, m_in_tlast, m_in_tvalid,
    input  m_in_tready,
    input  s_out_tdata, s_out_tkeep, s_out_tlast, s_out_tvalid,
    output s_out_tready
  );

  modport master (
    output s_instruct_0_tdata, s_instruct_1_tdata, s_instruct_0_tvalid, s_instruct_1_tvalid,
    input  s_instruct_0_tready, s_instruct_1_tready,
    output s_in_0_tdata, s_in_1_tdata, s_in_0_tkeep, s_in_1_tkeep,
    output s_in_0_tlast, s_in_1_tlast, s_in_0_tvalid, s_in_1_tvalid,
    input  s_in_0_tready, s_in_1_tready,
    input  m_out_0_tdata, m_out_1_tdata, m_out_0_tkeep, m_out_1_tkeep,
    input  m_out_0_tlast, m_out_1_tlast, m_out_0_tvalid, m_out_1_tvalid,
    output m_out_0_tready, m_out_1_tready,
    input  m_instruct_tdata, m_instruct_tvalid,
    output m_instruct_tready,
    input  m_in_tdata, m_in_tkeep, m_in_tlast, m_in_tvalid,
    output m_in_tready,
    output s_out_tdata, s_out_tkeep, s_out_tlast, s_out_tvalid,
    input  s_out_tready
  );
endinterface

// File: rtl/bram_stream_arbiter.sv
// Round-robin two-requester scheduler for the single-port stream buffer:
// one instruction at a time, data routed until tlast, then re-arbitrate.
module bram_stream_arbiter #(
  parameter int INST_W = 64,
  parameter int DATA_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_stream_arbiter_if.slave bus,
  output logic                 grant,
  output logic                 busy
);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t            state, state_n;
  logic              last_grant;
  logic [INST_W-1:0] inst_q;
  logic              win, take, done, op_rd, len_zero;
  logic [DATA_W-1:0] sel_tdata;
  logic [KEEP_W-1:0] sel_tkeep;
  logic              sel_tlast, sel_tvalid, sel_out_tready;

  assign op_rd    = inst_q[INST_W-1];
  assign len_zero = (inst_q[12:0] == '0);
  assign busy     = (state != S_IDLE);

  // Tie goes to whoever was not served last; otherwise the sole valid requester.
  assign win = (bus.s_instruct_0_tvalid && bus.s_instruct_1_tvalid) ? ~last_grant
                                                                    : bus.s_instruct_1_tvalid;

  assign sel_tdata      = grant ? bus.s_in_1_tdata  : bus.s_in_0_tdata;
  assign sel_tkeep      = grant ? bus.s_in_1_tkeep  : bus.s_in_0_tkeep;
  assign sel_tlast      = grant ? bus.s_in_1_tlast  : bus.s_in_0_tlast;
  assign sel_tvalid     = grant ? bus.s_in_1_tvalid : bus.s_in_0_tvalid;
  assign sel_out_tready = grant ? bus.m_out_1_tready : bus.m_out_0_tready;

  assign bus.m_instruct_tdata = inst_q;
  assign bus.m_in_tdata       = sel_tdata;
  assign bus.m_in_tkeep       = sel_tkeep;
  assign bus.m_in_tlast       = sel_tlast;
  assign bus.m_out_0_tdata    = bus.s_out_tdata;
  assign bus.m_out_0_tkeep    = bus.s_out_tkeep;
  assign bus.m_out_0_tlast    = bus.s_out_tlast;
  assign bus.m_out_1_tdata    = bus.s_out_tdata;
  assign bus.m_out_1_tkeep    = bus.s_out_tkeep;
  assign bus.m_out_1_tlast    = bus.s_out_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      inst_q     <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        inst_q <= win ? bus.s_instruct_1_tdata : bus.s_instruct_0_tdata;
        grant  <= win;
      end
      if (done) last_grant <= grant;
    end
  end

  always_comb begin
    state_n                 = state;
    take                    = 1'b0;
    done                    = 1'b0;
    bus.s_instruct_0_tready = 1'b0;
    bus.s_instruct_1_tready = 1'b0;
    bus.m_instruct_tvalid   = 1'b0;
    bus.m_in_tvalid         = 1'b0;
    bus.s_in_0_tready       = 1'b0;
    bus.s_in_1_tready       = 1'b0;
    bus.m_out_0_tvalid      = 1'b0;
    bus.m_out_1_tvalid      = 1'b0;
    bus.s_out_tready        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.s_instruct_0_tvalid || bus.s_instruct_1_tvalid) begin
          take                    = 1'b1;
          bus.s_instruct_0_tready = ~win;
          bus.s_instruct_1_tready = win;
          state_n                 = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.m_instruct_tvalid = 1'b1;
        if (bus.m_instruct_tready) begin
          done    = len_zero;
          state_n = len_zero ? S_IDLE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!op_rd) begin
          bus.m_in_tvalid   = sel_tvalid;
          bus.s_in_0_tready = ~grant & bus.m_in_tready;
          bus.s_in_1_tready = grant & bus.m_in_tready;
          done              = sel_tvalid & bus.m_in_tready & sel_tlast;
        end else begin
          bus.m_out_0_tvalid = ~grant & bus.s_out_tvalid;
          bus.m_out_1_tvalid = grant & bus.s_out_tvalid;
          bus.s_out_tready   = sel_out_tready;
          done               = bus.s_out_tvalid & sel_out_tready & bus.s_out_tlast;
        end
        if (done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_bram_stream_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bram_stream_arbiter;
  localparam int INST_W = 64;
  localparam int DATA_W = 128;
  localparam int KEEP_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant, busy;

  always #5 clk = ~clk;

  bram_stream_arbiter_if #(.INST_W(INST_W), .DATA_W(DATA_W)) bus ();

  bram_stream_arbiter #(.INST_W(INST_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .grant(grant),
    .busy (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record (owner, word, whether the buffer has taken the word).
  bit          m_act   = 1'b0;
  bit          m_sent  = 1'b0;
  bit          m_req   = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_grant = 1'b0;
  logic [63:0] m_word  = '0;

  logic e_win, e_take, e_itr0, e_itr1, e_ivalid, e_wr, e_rd, e_fin;
  logic e_in_valid, e_in_rdy0, e_in_rdy1, e_out_v0, e_out_v1, e_out_rdy;
  logic [DATA_W-1:0] e_src_data;
  logic [KEEP_W-1:0] e_src_keep;
  logic e_src_last, e_src_valid;

  always_comb begin
    e_win       = (bus.s_instruct_0_tvalid && bus.s_instruct_1_tvalid) ? !m_last : bus.s_instruct_1_tvalid;
    e_take      = !m_act && (bus.s_instruct_0_tvalid || bus.s_instruct_1_tvalid);
    e_itr0      = e_take && !e_win;
    e_itr1      = e_take && e_win;
    e_ivalid    = m_act && !m_sent;
    e_wr        = m_act && m_sent && !m_word[63];
    e_rd        = m_act && m_sent && m_word[63];
    e_src_data  = m_req ? bus.s_in_1_tdata  : bus.s_in_0_tdata;
    e_src_keep  = m_req ? bus.s_in_1_tkeep  : bus.s_in_0_tkeep;
    e_src_last  = m_req ? bus.s_in_1_tlast  : bus.s_in_0_tlast;
    e_src_valid = m_req ? bus.s_in_1_tvalid : bus.s_in_0_tvalid;
    e_in_valid  = e_wr && e_src_valid;
    e_in_rdy0   = e_wr && !m_req && bus.m_in_tready;
    e_in_rdy1   = e_wr && m_req && bus.m_in_tready;
    e_out_v0    = e_rd && !m_req && bus.s_out_tvalid;
    e_out_v1    = e_rd && m_req && bus.s_out_tvalid;
    e_out_rdy   = e_rd && (m_req ? bus.m_out_1_tready : bus.m_out_0_tready);
    e_fin       = (e_ivalid && bus.m_instruct_tready && (m_word[12:0] == 13'd0))
               || (e_in_valid && bus.m_in_tready && e_src_last)
               || (e_rd && bus.s_out_tvalid && e_out_rdy && bus.s_out_tlast);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_sent <= 1'b0; m_req <= 1'b0;
      m_last <= 1'b1; m_grant <= 1'b0; m_word <= '0;
    end else if (e_take) begin
      m_act   <= 1'b1;
      m_sent  <= 1'b0;
      m_req   <= e_win;
      m_grant <= e_win;
      m_word  <= e_win ? bus.s_instruct_1_tdata : bus.s_instruct_0_tdata;
    end else if (e_fin) begin
      m_act  <= 1'b0;
      m_last <= m_req;
    end else if (e_ivalid && bus.m_instruct_tready) begin
      m_sent <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("s_instruct_0_tready", bus.s_instruct_0_tready, e_itr0);
      check("s_instruct_1_tready", bus.s_instruct_1_tready, e_itr1);
      check("busy", busy, m_act);
      check("grant", grant, m_grant);
      check("m_instruct_tvalid", bus.m_instruct_tvalid, e_ivalid);
      if (e_ivalid) check("m_instruct_tdata", bus.m_instruct_tdata, m_word);
      check("m_in_tvalid", bus.m_in_tvalid, e_in_valid);
      if (e_in_valid) begin
        check("m_in_tdata", bus.m_in_tdata, e_src_data);
        check("m_in_tkeep", bus.m_in_tkeep, e_src_keep);
        check("m_in_tlast", bus.m_in_tlast, e_src_last);
      end
      check("s_in_0_tready", bus.s_in_0_tready, e_in_rdy0);
      check("s_in_1_tready", bus.s_in_1_tready, e_in_rdy1);
      check("m_out_0_tvalid", bus.m_out_0_tvalid, e_out_v0);
      check("m_out_1_tvalid", bus.m_out_1_tvalid, e_out_v1);
      if (e_out_v0) check("m_out_0_tdata", bus.m_out_0_tdata, bus.s_out_tdata);
      if (e_out_v1) begin
        check("m_out_1_tdata", bus.m_out_1_tdata, bus.s_out_tdata);
        check("m_out_1_tkeep", bus.m_out_1_tkeep, bus.s_out_tkeep);
        check("m_out_1_tlast", bus.m_out_1_tlast, bus.s_out_tlast);
      end
      check("s_out_tready", bus.s_out_tready, e_out_rdy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.s_instruct_0_tdata = '0; bus.s_instruct_0_tvalid = 1'b0;
    bus.s_instruct_1_tdata = '0; bus.s_instruct_1_tvalid = 1'b0;
    bus.s_in_0_tdata = '0; bus.s_in_0_tkeep = '0; bus.s_in_0_tlast = 1'b0; bus.s_in_0_tvalid = 1'b0;
    bus.s_in_1_tdata = '0; bus.s_in_1_tkeep = '0; bus.s_in_1_tlast = 1'b0; bus.s_in_1_tvalid = 1'b0;
    bus.m_out_0_tready = 1'b0; bus.m_out_1_tready = 1'b0;
    bus.m_instruct_tready = 1'b0; bus.m_in_tready = 1'b0;
    bus.s_out_tdata = '0; bus.s_out_tkeep = '0; bus.s_out_tlast = 1'b0; bus.s_out_tvalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[12:0] = 13'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic likely();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_grant"}, grant, 1'b0);
    check({tag, "_m_instruct_tvalid"}, bus.m_instruct_tvalid, 1'b0);
    check({tag, "_m_in_tvalid"}, bus.m_in_tvalid, 1'b0);
    check({tag, "_s_in_0_tready"}, bus.s_in_0_tready, 1'b0);
    check({tag, "_s_out_tready"}, bus.s_out_tready, 1'b0);
  endtask

  initial begin
    bit order[$];
    int cyc;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    check("reset_m_instruct_tdata", bus.m_instruct_tdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single write from requester 0 with 5 cycles of instruction backpressure.
    step();
    bus.s_instruct_0_tdata = 64'h0000_0000_0000_2004;
    bus.s_instruct_0_tvalid = 1'b1;
    @(negedge clk);
    check("wr_s_instruct_0_tready", bus.s_instruct_0_tready, 1'b1);
    step();
    bus.s_instruct_0_tvalid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wr_hold_tvalid", bus.m_instruct_tvalid, 1'b1);
      check("wr_hold_tdata", bus.m_instruct_tdata, 64'h0000_0000_0000_2004);
      step();
    end
    bus.m_instruct_tready = 1'b1;
    @(negedge clk);
    check("wr_issue_tdata", bus.m_instruct_tdata, 64'h0000_0000_0000_2004);
    step();
    bus.m_instruct_tready = 1'b0;
    bus.m_in_tready = 1'b1;
    bus.s_in_1_tvalid = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      bus.s_in_0_tdata = DATA_W'(i);
      bus.s_in_0_tkeep = '1;
      bus.s_in_0_tlast = (i == 4);
      bus.s_in_0_tvalid = 1'b1;
      @(negedge clk);
      check("wr_beat_valid", bus.m_in_tvalid, 1'b1);
      check("wr_beat_data", bus.m_in_tdata, 128'(i));
      check("wr_s_in_1_tready", bus.s_in_1_tready, 1'b0);
      step();
    end
    clear_inputs();
    @(negedge clk);
    check("wr_done_busy", busy, 1'b0);
    check("wr_done_grant", grant, 1'b0);

    // Single read for requester 1.
    step();
    bus.s_instruct_1_tdata = 64'h8000_0000_0000_0003;
    bus.s_instruct_1_tvalid = 1'b1;
    bus.m_instruct_tready = 1'b1;
    @(negedge clk);
    check("rd_s_instruct_1_tready", bus.s_instruct_1_tready, 1'b1);
    step();
    bus.s_instruct_1_tvalid = 1'b0;
    @(negedge clk);
    check("rd_issue_tdata", bus.m_instruct_tdata, 64'h8000_0000_0000_0003);
    step();
    bus.m_instruct_tready = 1'b0;
    bus.m_out_0_tready = 1'b1;
    bus.m_out_1_tready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      bus.s_out_tdata = DATA_W'(100 + i);
      bus.s_out_tkeep = '1;
      bus.s_out_tlast = (i == 3);
      bus.s_out_tvalid = 1'b1;
      @(negedge clk);
      check("rd_m_out_1_tvalid", bus.m_out_1_tvalid, 1'b1);
      check("rd_m_out_1_tdata", bus.m_out_1_tdata, 128'(100 + i));
      check("rd_m_out_0_tvalid", bus.m_out_0_tvalid, 1'b0);
      step();
    end
    clear_inputs();
    @(negedge clk);
    check("rd_done_grant", grant, 1'b1);
    check("rd_done_busy", busy, 1'b0);

    // Zero-length instruction completes straight out of the issue phase.
    step();
    bus.s_instruct_0_tdata = 64'h0000_0000_0000_2000;
    bus.s_instruct_0_tvalid = 1'b1;
    bus.m_instruct_tready = 1'b1;
    step();
    bus.s_instruct_0_tvalid = 1'b0;
    bus.s_in_0_tvalid = 1'b1;
    bus.m_in_tready = 1'b1;
    @(negedge clk);
    check("len0_issue_busy", busy, 1'b1);
    step();
    @(negedge clk);
    check("len0_done_busy", busy, 1'b0);
    check("len0_m_in_tvalid", bus.m_in_tvalid, 1'b0);
    clear_inputs();

    // Reset in the middle of an 8-beat write, after two beats.
    step();
    bus.s_instruct_0_tdata = 64'h0000_0000_0000_4008;
    bus.s_instruct_0_tvalid = 1'b1;
    bus.m_instruct_tready = 1'b1;
    step();
    bus.s_instruct_0_tvalid = 1'b0;
    step();
    bus.m_instruct_tready = 1'b0;
    bus.m_in_tready = 1'b1;
    bus.s_in_0_tvalid = 1'b1;
    bus.s_in_0_tdata = 128'd1;
    step();
    bus.s_in_0_tdata = 128'd2;
    step();
    bus.s_in_0_tdata = 128'd3;
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Contention straight after reset: order must alternate starting at requester 0.
    step();
    bus.s_instruct_0_tdata = 64'h0000_0000_0000_6001;
    bus.s_instruct_1_tdata = 64'h0000_0000_0000_8001;
    bus.s_instruct_0_tvalid = 1'b1;
    bus.s_instruct_1_tvalid = 1'b1;
    bus.m_instruct_tready = 1'b1;
    bus.m_in_tready = 1'b1;
    bus.s_in_0_tvalid = 1'b1; bus.s_in_0_tlast = 1'b1; bus.s_in_0_tdata = 128'hA0;
    bus.s_in_1_tvalid = 1'b1; bus.s_in_1_tlast = 1'b1; bus.s_in_1_tdata = 128'hB1;
    cyc = 0;
    while (order.size() < 8 && cyc < 200) begin
      @(negedge clk);
      if (busy) check("cont_loser_tready", {bus.s_instruct_0_tready, bus.s_instruct_1_tready}, 2'b00);
      if (bus.m_instruct_tvalid && bus.m_instruct_tready) order.push_back(grant);
      step();
      cyc++;
    end
    check("cont_issue_count", order.size(), 8);
    for (int unsigned i = 0; i < order.size(); i++)
      check($sformatf("cont_order_%0d", i), order[i], i[0]);
    clear_inputs();
    repeat (4) step();

    // Randomized traffic on every input, judged by the reference model each cycle.
    for (int unsigned n = 0; n < 4000; n++) begin
      bus.s_instruct_0_tvalid = ($urandom_range(0, 2) == 0);
      bus.s_instruct_0_tdata  = rand_word();
      bus.s_instruct_1_tvalid = ($urandom_range(0, 2) == 0);
      bus.s_instruct_1_tdata  = rand_word();
      bus.s_in_0_tvalid = likely(); bus.s_in_0_tdata = rand_data();
      bus.s_in_0_tkeep  = KEEP_W'($urandom); bus.s_in_0_tlast = ($urandom_range(0, 2) == 0);
      bus.s_in_1_tvalid = likely(); bus.s_in_1_tdata = rand_data();
      bus.s_in_1_tkeep  = KEEP_W'($urandom); bus.s_in_1_tlast = ($urandom_range(0, 2) == 0);
      bus.s_out_tvalid  = likely(); bus.s_out_tdata = rand_data();
      bus.s_out_tkeep   = KEEP_W'($urandom); bus.s_out_tlast = ($urandom_range(0, 2) == 0);
      bus.m_out_0_tready = likely();
      bus.m_out_1_tready = likely();
      bus.m_in_tready    = likely();
      bus.m_instruct_tready = ($urandom_range(0, 1) == 1);
      step();
    end
    clear_inputs();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
